run_sequencer: RTL

- Owns the Start/Ack protocol between the testbench and the core, and sequences each program run: select program, load PC, enable core, detect halt or timeout, report done.
- Sits between the top-level Start/Ack pins and ProgCtr, the instruction-gating logic and the Ctrl done flag.
- Replaces the ad-hoc ever_start/should_run logic and the free-running cycle counter.
- Adds per-run cycle measurement and a watchdog.

---
 rtl/run_pkg.sv | 26 ++
 rtl/run_cycle_counter.sv | 39 +++
 rtl/run_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/run_pkg.sv
// Shared types and constants for the run sequencer: state encoding, program
// base-address table and the NOP encoding fed to the core while it is gated.
package run_pkg;

    localparam int unsigned BASE_W   = 10;
    localparam int unsigned NUM_BASE = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LOAD,
        RUN,
        DONE
    } run_state_t;

    localparam logic [BASE_W-1:0] BASE_TABLE [NUM_BASE] = '{
        10'h000, 10'h100, 10'h200, 10'h300
    };

    localparam logic [8:0] NOP_INST = 9'h1FF;

    function automatic logic [BASE_W-1:0] base_addr(input logic [1:0] idx);
        return BASE_TABLE[idx];
    endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Per-run cycle counter: synchronous clear, count enable, saturation at
// all-ones, and a watchdog limit compare (disabled when MAX_CYCLES is 0).
module run_cycle_counter #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_CYCLES = 32'hFFF0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count_q,
    output logic             limit_hit_c
);

    localparam bit              WD_EN = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0] LIMIT = WD_EN ? CNT_W'(MAX_CYCLES - 1) : '0;

    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign limit_hit_c = WD_EN && (count_q == LIMIT);

endmodule

// File: rtl/run_sequencer.sv
// Start/Ack run sequencer: arms on Start, launches on its falling edge, loads
// the PC, enables the core until halt or watchdog, and reports completion.
module run_sequencer
    import run_pkg::*;
#(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_CYCLES = 32'hFFF0,
    parameter int unsigned NUM_PROGS  = 4
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic [$clog2(NUM_PROGS)-1:0] ProgSel,
    input  logic                         CoreHalt,
    output logic                         PCLoad,
    output logic [PC_W-1:0]              PCLoadAddr,
    output logic                         CoreEn,
    output logic                         Ack,
    output logic                         Timeout,
    output logic [CNT_W-1:0]             CycleCount,
    output logic [$clog2(NUM_PROGS)-1:0] ActiveProg
);

    localparam int unsigned SEL_W = $clog2(NUM_PROGS);

    run_state_t       state_q, state_d;
    logic [SEL_W-1:0] active_prog_q, active_prog_d;
    logic             timeout_q, timeout_d;
    logic [SEL_W-1:0] sel_mapped;
    logic             cnt_clr;
    logic             cnt_en;
    logic             limit_hit;

    // Out-of-range selections fall back to program 0.
    always_comb begin
        sel_mapped = ProgSel;
        if ((32'(ProgSel) >= NUM_PROGS) || (32'(ProgSel) >= NUM_BASE)) begin
            sel_mapped = '0;
        end
    end

    always_comb begin
        state_d       = state_q;
        active_prog_d = active_prog_q;
        timeout_d     = timeout_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d       = ARMED;
                    active_prog_d = sel_mapped;
                    timeout_d     = 1'b0;
                    cnt_clr       = 1'b1;
                end
            end
            ARMED: begin
                if (!Start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (Start) begin
                    state_d       = ARMED;
                    active_prog_d = sel_mapped;
                    timeout_d     = 1'b0;
                    cnt_clr       = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (Start) begin
                    state_d       = ARMED;
                    active_prog_d = sel_mapped;
                    timeout_d     = 1'b0;
                    cnt_clr       = 1'b1;
                end else begin
                    // Halt takes priority over the watchdog in the same cycle.
                    cnt_en = 1'b1;
                    if (CoreHalt) begin
                        state_d = DONE;
                    end else if (limit_hit) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            active_prog_q <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_prog_q <= active_prog_d;
            timeout_q     <= timeout_d;
        end
    end

    run_cycle_counter #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cycle_counter (
        .clk         (Clk),
        .rst         (Reset),
        .clr         (cnt_clr),
        .en          (cnt_en),
        .count_q     (CycleCount),
        .limit_hit_c (limit_hit)
    );

    assign PCLoad     = (state_q == LOAD);
    assign CoreEn     = (state_q == RUN);
    assign Ack        = (state_q == DONE);
    assign Timeout    = timeout_q;
    assign ActiveProg = active_prog_q;
    assign PCLoadAddr = PC_W'(base_addr(2'(active_prog_q)));

endmodule
